islip_sched: RTL and testbench

//  Parametrised iSLIP crossbar scheduler for the switch core. Generalises the fixed 4x4 single-shot arbiter to N x N ports with ITER request-grant-accept iterations.

---
 rtl/islip_sched_pkg.sv | 7 +
 rtl/islip_sched_rr_prio_arb.sv | 25 ++
 rtl/islip_sched.sv | 111 +++++++++++
 tb/tb_islip_sched.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/islip_sched_pkg.sv
// islip_pkg: shared FSM state encodings for the iSLIP crossbar scheduler.
package islip_pkg;
  localparam logic [3:0] ARB_STATE_IDLE = 4'b0001;
  localparam logic [3:0] ARB_STATE_GRNT = 4'b0010;
  localparam logic [3:0] ARB_STATE_ACPT = 4'b0100;
  localparam logic [3:0] ARB_STATE_WAIT = 4'b1000;
endpackage

// File: rtl/islip_sched_rr_prio_arb.sv
// rr_prio_arb: combinational round-robin pick of the first set bit at or after ptr_i.
module rr_prio_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o
);
  localparam int PW = $clog2(N);
  always_comb begin
    int c;
    gnt_o = '0;
    idx_o = '0;
    // scan from farthest to nearest so the nearest hit is the last write
    for (int k = N - 1; k >= 0; k--) begin
      c = (int'(ptr_i) + k) % N;
      if (req_i[c]) begin
        gnt_o = '0;
        gnt_o[c] = 1'b1;
        idx_o = PW'(c);
      end
    end
  end
endmodule

// File: rtl/islip_sched.sv
// islip_sched: N x N iSLIP scheduler, ITER request-grant-accept rounds per request matrix.
module islip_sched
  import islip_pkg::*;
#(
  parameter int N    = 4,
  parameter int ITER = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           arb_valid_in,
  output logic           arb_ready_in,
  input  logic [N*N-1:0] rx_req_vect,
  input  logic [N-1:0]   tx_rdy_vect,
  output logic           arb_valid_out,
  input  logic           arb_ready_out,
  output logic [N*N-1:0] arb_vect
);
  localparam int PW = $clog2(N);
  typedef logic [N-1:0][N-1:0] mat_t;
  typedef logic [N-1:0][PW-1:0] ptr_t;
  logic [3:0] state_q, state_d;
  mat_t req_q, req_d, match_q, match_d, rx_m, greq, areq, g_one, a_one, vect_q;
  ptr_t gptr_q, gptr_d, aptr_q, aptr_d, gi_q, gi_d, g_idx, a_idx;
  logic [N-1:0] gv_q, gv_d, out_m;
  logic [PW-1:0] iter_q, iter_d;
  logic rdy_q, vld_q;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] x);
    return (x == PW'(N - 1)) ? '0 : x + 1'b1;
  endfunction
  assign rx_m          = rx_req_vect;
  assign arb_ready_in  = rdy_q;
  assign arb_valid_out = vld_q;
  assign arb_vect      = vect_q;
  always_comb begin
    out_m = '0;
    for (int i = 0; i < N; i++) out_m |= match_q[i];
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        greq[j][i] = req_q[i][j] & !(|match_q[i]) & ~out_m[j];
        areq[i][j] = gv_q[j] && (gi_q[j] == PW'(i));
      end
  end
  for (genvar g = 0; g < N; g++) begin : g_arb
    rr_prio_arb #(.N(N)) u_grnt (.req_i(greq[g]), .ptr_i(gptr_q[g]), .gnt_o(g_one[g]), .idx_o(g_idx[g]));
    rr_prio_arb #(.N(N)) u_acpt (.req_i(areq[g]), .ptr_i(aptr_q[g]), .gnt_o(a_one[g]), .idx_o(a_idx[g]));
  end
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    match_d = match_q;
    gv_d    = gv_q;
    gi_d    = gi_q;
    iter_d  = iter_q;
    gptr_d  = gptr_q;
    aptr_d  = aptr_q;
    case (state_q)
      ARB_STATE_IDLE: if (arb_valid_in && rdy_q) begin
        for (int i = 0; i < N; i++) req_d[i] = rx_m[i] & tx_rdy_vect;
        match_d = '0;
        iter_d  = '0;
        state_d = ARB_STATE_GRNT;
      end
      ARB_STATE_GRNT: begin
        for (int j = 0; j < N; j++) gv_d[j] = |g_one[j];
        gi_d    = g_idx;
        state_d = ARB_STATE_ACPT;
      end
      ARB_STATE_ACPT: begin
        match_d = match_q | a_one;
        // only first-iteration accepts move the pointers, keeping them desynchronised
        if (iter_q == '0)
          for (int i = 0; i < N; i++)
            if (|a_one[i]) begin
              aptr_d[i]        = inc(a_idx[i]);
              gptr_d[a_idx[i]] = inc(PW'(i));
            end
        iter_d  = (iter_q == PW'(ITER - 1)) ? iter_q : iter_q + 1'b1;
        state_d = (iter_q == PW'(ITER - 1)) ? ARB_STATE_WAIT : ARB_STATE_GRNT;
      end
      ARB_STATE_WAIT: if (arb_ready_out) state_d = ARB_STATE_IDLE;
      default: state_d = ARB_STATE_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ARB_STATE_IDLE;
      req_q   <= '0;
      match_q <= '0;
      gv_q    <= '0;
      gi_q    <= '0;
      iter_q  <= '0;
      gptr_q  <= '0;
      aptr_q  <= '0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      vect_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      match_q <= match_d;
      gv_q    <= gv_d;
      gi_q    <= gi_d;
      iter_q  <= iter_d;
      gptr_q  <= gptr_d;
      aptr_q  <= aptr_d;
      rdy_q   <= state_d == ARB_STATE_IDLE;
      vld_q   <= state_d == ARB_STATE_WAIT;
      vect_q  <= (state_d == ARB_STATE_WAIT) ? match_d : '0;
    end
  end
endmodule

// File: tb/tb_islip_sched.sv
// tb_islip_sched: randomized check of ITER=1 and ITER=4 schedulers against an iSLIP reference model.
module tb_islip_sched;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic v1 = 1'b0, v4 = 1'b0, rdy_out = 1'b1;
  logic [15:0] rx = '0;
  logic [3:0] tx = 4'hF;
  logic rin1, rin4, vo1, vo4;
  logic [15:0] av1, av4, got;
  int checks = 0, errors = 0;
  int gp[2][4], ap[2][4];
  always #5 clk = ~clk;
  islip_sched #(.N(4), .ITER(1)) u1 (
    .clk(clk), .rst(rst), .arb_valid_in(v1), .arb_ready_in(rin1), .rx_req_vect(rx),
    .tx_rdy_vect(tx), .arb_valid_out(vo1), .arb_ready_out(rdy_out), .arb_vect(av1));
  islip_sched #(.N(4), .ITER(4)) u4 (
    .clk(clk), .rst(rst), .arb_valid_in(v4), .arb_ready_in(rin4), .rx_req_vect(rx),
    .tx_rdy_vect(tx), .arb_valid_out(vo4), .arb_ready_out(rdy_out), .arb_vect(av4));
  function automatic logic rin(input int s);
    return (s != 0) ? rin4 : rin1;
  endfunction
  function automatic logic vout(input int s);
    return (s != 0) ? vo4 : vo1;
  endfunction
  function automatic logic [15:0] avec(input int s);
    return (s != 0) ? av4 : av1;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 4; k++) begin
        gp[s][k] = 0;
        ap[s][k] = 0;
      end
  endtask
  task automatic model(input int s, input logic [15:0] req, input logic [3:0] rdy, output logic [15:0] m);
    int g[4];
    bit im[4], om[4];
    int i, j;
    m = '0;
    for (int k = 0; k < 4; k++) begin
      im[k] = 0;
      om[k] = 0;
    end
    for (int it = 0; it < ((s != 0) ? 4 : 1); it++) begin
      for (int jj = 0; jj < 4; jj++) begin
        g[jj] = -1;
        if (!om[jj])
          for (int k = 0; k < 4; k++) begin
            i = (gp[s][jj] + k) % 4;
            if (req[i*4+jj] && rdy[jj] && !im[i]) begin
              g[jj] = i;
              break;
            end
          end
      end
      for (int ii = 0; ii < 4; ii++)
        if (!im[ii])
          for (int k = 0; k < 4; k++) begin
            j = (ap[s][ii] + k) % 4;
            if (g[j] == ii) begin
              m[ii*4+j] = 1'b1;
              im[ii] = 1;
              om[j] = 1;
              if (it == 0) begin
                gp[s][j] = (ii + 1) % 4;
                ap[s][ii] = (j + 1) % 4;
              end
              break;
            end
          end
    end
  endtask
  task automatic xact(input int s, input logic [15:0] req, input logic [3:0] rdy, input int hold,
                      output logic [15:0] res);
    int n;
    logic [15:0] exp;
    n = 0;
    while (!rin(s) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_in", 32'(rin(s)), 32'd1);
    rx = req;
    tx = rdy;
    rdy_out = (hold == 0);
    if (s != 0) v4 = 1'b1; else v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    v4 = 1'b0;
    rx = 16'($urandom);
    tx = 4'($urandom);
    model(s, req, rdy, exp);
    n = 1;
    while (!vout(s) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(2 * ((s != 0) ? 4 : 1) + 1));
    res = avec(s);
    chk("arb_vect", 32'(res), 32'(exp));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      rx = 16'($urandom);
      chk("hold_valid", 32'(vout(s)), 32'd1);
      chk("hold_vect", 32'(avec(s)), 32'(exp));
      chk("hold_ready_in", 32'(rin(s)), 32'd0);
    end
    rdy_out = 1'b1;
    @(negedge clk);
    chk("drop_valid", 32'(vout(s)), 32'd0);
    chk("drop_vect", 32'(avec(s)), 32'd0);
  endtask
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ready_in", 32'(rin1), 32'd0);
    chk("rst_valid", 32'(vo1), 32'd0);
    chk("rst_vect", 32'(av1), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready1", 32'(rin1), 32'd1);
    chk("post_rst_ready4", 32'(rin4), 32'd1);
    xact(0, 16'h0013, 4'hF, 0, got);
    chk("s1_const", 32'(got), 32'h0001);
    xact(1, 16'hFFFF, 4'hF, 0, got);
    chk("s2a_const", 32'(got), 32'h8421);
    xact(1, 16'hFFFF, 4'hF, 0, got);
    chk("s2b_const", 32'(got), 32'h8412);
    xact(1, 16'hFFFF, 4'hE, 0, got);
    chk("s3_col0", 32'(got & 16'h1111), 32'd0);
    xact(1, 16'($urandom), 4'hF, 5, got);
    xact(0, 16'h0000, 4'hF, 0, got);
    xact(0, 16'h0013, 4'hF, 0, got);
    chk("s6_followup", 32'(got), 32'h0012);
    // abort an ITER=4 run in its first accept cycle
    while (!rin4) @(negedge clk);
    rx = 16'hFFFF;
    tx = 4'hF;
    v4 = 1'b1;
    @(negedge clk);
    v4 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", 32'(rin4), 32'd0);
    chk("mid_rst_valid", 32'(vo4), 32'd0);
    chk("mid_rst_vect", 32'(av4), 32'd0);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("mid_rst_release", 32'(rin4), 32'd1);
    xact(0, 16'h0013, 4'hF, 0, got);
    chk("s5_rerun", 32'(got), 32'h0001);
    for (int r = 0; r < 40; r++)
      xact(r % 2, 16'($urandom), 4'($urandom), int'($urandom_range(0, 3)), got);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
